out_buf: RTL and testbench
==========================

OUT_BUF -- requirements
Module: out_buf

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning the width of each stored result word.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning the number of entries; it must be a power of two and at least 2.
REQ-003 The block SHALL have parameter ADDR_W, default 4, equal to log2(DEPTH).
REQ-004 The block SHALL have the following ports, one per line as name, direction, width, meaning:
 clk  in  1  single clock; all state updates on its rising edge.
 buf_rst_n  in  1  reset; synchronous, active-low.
 buf_input_select  in  1  1 = accept the BN output, 0 = accept the SA output.
 buf_output_select  in  1  1 = drain to weight_pref, 0 = drain to input_pref.
 flush  in  1  synchronous clear of all contents.
 sa_valid  in  1  SA result word valid.
 sa_data  in  DATA_W  SA result word.
 bn_valid  in  1  BN result word valid.
 bn_data  in  DATA_W  BN result word.
 in_ready  out  1  buffer can accept a word this cycle.
 inpref_valid  out  1  word presented to input_pref.
 inpref_ready  in  1  input_pref accepts the word.
 wpref_valid  out  1  word presented to weight_pref.
 wpref_ready  in  1  weight_pref accepts the word.
 out_data  out  DATA_W  head word, shared by both destinations.
 count  out  ADDR_W+1  current occupancy, from 0 to DEPTH.
 full  out  1  count == DEPTH.
 empty  out  1  count == 0.
 overflow  out  1  sticky flag set by a dropped write.
 ovf_count  out  8  count of dropped writes.

Function
REQ-005 The buffer SHALL be a circular FIFO with wr_ptr and rd_ptr of width ADDR_W that wrap modulo DEPTH, and the count register SHALL be the single source for the full and empty outputs.
REQ-006 The write request wr_req SHALL equal bn_valid when buf_input_select=1 and sa_valid otherwise; the valid of the unselected source SHALL be ignored.
REQ-007 The selected data word SHALL be written at wr_ptr when wr_req && in_ready, after which wr_ptr SHALL advance by 1.
REQ-008 in_ready SHALL equal !full and SHALL NOT depend on a read in the same cycle, so a write while full is rejected even if a read occurs that cycle.
REQ-009 out_data SHALL equal mem[rd_ptr], and out_valid SHALL equal !empty.
REQ-010 inpref_valid SHALL be out_valid && !buf_output_select, and wpref_valid SHALL be out_valid && buf_output_select.
REQ-011 A read SHALL occur when the valid and ready of the selected destination are both 1; rd_ptr SHALL then advance by 1, and the ready of the unselected destination SHALL be ignored.
REQ-012 Latency SHALL be 1 cycle: a word written at edge N is presented on out_data with valid after edge N, and there is no combinational bypass from input to output.
REQ-013 A simultaneous write and read SHALL leave count unchanged and advance both pointers.
REQ-014 When count == DEPTH-1 and a write occurs with no read, count SHALL become DEPTH and full SHALL assert after that edge.
REQ-015 When empty, no read SHALL occur and both destination valids SHALL be 0.
REQ-016 A write attempt with wr_req=1 while full SHALL be dropped; memory and pointers SHALL be unchanged and overflow SHALL be set to 1.
REQ-017 flush=1 SHALL set wr_ptr, rd_ptr and count to 0 at the next edge and SHALL take priority over any write or read in the same cycle; overflow and ovf_count SHALL be unaffected by flush.
REQ-018 A change of either select input SHALL take effect in the same cycle, and buffer contents SHALL be preserved across the change.

Reset
REQ-019 When buf_rst_n=0 at a rising edge, wr_ptr, rd_ptr, count, overflow and ovf_count SHALL become 0, giving empty=1, full=0, in_ready=1 and both destination valids 0.
REQ-020 Reset SHALL take priority over flush, write and read, and any contents present mid-operation SHALL be discarded.
REQ-021 Memory contents SHALL NOT be reset, and out_data SHALL be don't-care while empty.

Configuration
REQ-022 When macro OUT_BUF_OVF_CNT_EN is defined, ovf_count SHALL increment by 1 on each dropped write and saturate at 255.
REQ-023 When OUT_BUF_OVF_CNT_EN is undefined, ovf_count SHALL be tied to 0, no counter logic SHALL be present, and the overflow flag SHALL still operate.

Verification
REQ-024 Reset then write 3 SA words 0x0011, 0x0022, 0x0033 with buf_input_select=0 and inpref_ready=0 -> count=3, inpref_valid=1, out_data=0x0011, wpref_valid=0.
REQ-025 Fill 16 BN words with buf_input_select=1, then assert bn_valid for 2 more cycles -> full=1, in_ready=0, overflow=1, ovf_count=2 with the macro defined and 0 without it, and contents unchanged.
REQ-026 Full buffer, simultaneous write attempt and wpref read with buf_output_select=1 -> write dropped, count=15, rd_ptr advanced by 1.
REQ-027 Write 20 words while draining with inpref_ready toggling -> order is preserved across the pointer wrap, and empty=1 and count=0 at the end.
REQ-028 count=5, assert flush together with sa_valid=1 -> next cycle count=0 and empty=1, with the write dropped.
REQ-029 Pull buf_rst_n low for one cycle mid-stream with count=7 and overflow=1 -> next cycle count=0, overflow=0, and both destination valids 0.

Source files
------------

// File: rtl/out_buf.sv
// out_buf: circular result buffer between the SA/BN result sources and the
// input_pref / weight_pref consumers.
//
// Optional feature: define OUT_BUF_OVF_CNT_EN to build a saturating 8-bit
// counter of dropped writes on ovf_count. Without it ovf_count is tied to 0;
// the sticky overflow flag works in both builds.
//
// Handshakes: a word moves on a rising edge exactly when valid and ready are
// both 1 on that interface. The producer side has no back-pressure of its own,
// so a selected valid that meets in_ready=0 is a dropped write. Valid never
// depends combinationally on ready, and in_ready never depends on a read.
module out_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              buf_rst_n,
  input  logic              buf_input_select,
  input  logic              buf_output_select,
  input  logic              flush,
  input  logic              sa_valid,
  input  logic [DATA_W-1:0] sa_data,
  input  logic              bn_valid,
  input  logic [DATA_W-1:0] bn_data,
  output logic              in_ready,
  output logic              inpref_valid,
  input  logic              inpref_ready,
  output logic              wpref_valid,
  input  logic              wpref_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic [7:0]        ovf_count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  logic              wr_req;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic              rd_en;
  logic              out_valid;
  logic              drop;

  // count is the only source of full/empty; in_ready ignores same-cycle reads
  assign full      = (count == (ADDR_W+1)'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;

  // source selection: the unselected valid is ignored entirely
  assign wr_req  = buf_input_select ? bn_valid : sa_valid;
  assign wr_data = buf_input_select ? bn_data  : sa_data;
  assign wr_en   = wr_req && in_ready;
  assign drop    = wr_req && full;

  // destination steering: the unselected ready is ignored entirely
  assign inpref_valid = out_valid && !buf_output_select;
  assign wpref_valid  = out_valid &&  buf_output_select;
  assign rd_en        = out_valid &&
                        (buf_output_select ? wpref_ready : inpref_ready);

  // head word is read straight from storage; no path from input to output
  assign out_data = mem[rd_ptr];

  // storage array, intentionally not reset; writes suppressed by reset/flush
  always_ff @(posedge clk) begin
    if (buf_rst_n && !flush && wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // pointers and occupancy; reset beats flush, flush beats write/read
  always_ff @(posedge clk) begin
    if (!buf_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // sticky overflow flag; only reset clears it, flush leaves it alone
  always_ff @(posedge clk) begin
    if (!buf_rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

`ifdef OUT_BUF_OVF_CNT_EN
  logic [7:0] ovf_cnt_q;

  // saturating count of dropped writes; only reset clears it
  always_ff @(posedge clk) begin
    if (!buf_rst_n) begin
      ovf_cnt_q <= '0;
    end else if (drop && (ovf_cnt_q != 8'hFF)) begin
      ovf_cnt_q <= ovf_cnt_q + 8'd1;
    end
  end

  assign ovf_count = ovf_cnt_q;
`else
  assign ovf_count = 8'd0;
`endif

endmodule

// File: tb/tb_out_buf.sv
// tb_out_buf: directed scenarios plus randomized traffic for out_buf, checked
// against a queue-based model of the buffer.
module tb_out_buf;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              buf_rst_n;
  logic              buf_input_select, buf_output_select, flush;
  logic              sa_valid, bn_valid;
  logic [DATA_W-1:0] sa_data, bn_data;
  logic              in_ready, inpref_valid, inpref_ready;
  logic              wpref_valid, wpref_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W:0]   count;
  logic              full, empty, overflow;
  logic [7:0]        ovf_count;

  always #5 clk = ~clk;

  out_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk               (clk),
    .buf_rst_n         (buf_rst_n),
    .buf_input_select  (buf_input_select),
    .buf_output_select (buf_output_select),
    .flush             (flush),
    .sa_valid          (sa_valid),
    .sa_data           (sa_data),
    .bn_valid          (bn_valid),
    .bn_data           (bn_data),
    .in_ready          (in_ready),
    .inpref_valid      (inpref_valid),
    .inpref_ready      (inpref_ready),
    .wpref_valid       (wpref_valid),
    .wpref_ready       (wpref_ready),
    .out_data          (out_data),
    .count             (count),
    .full              (full),
    .empty             (empty),
    .overflow          (overflow),
    .ovf_count         (ovf_count)
  );

  // ---------------- scoreboard / model state ----------------
  logic [DATA_W-1:0] exp_q[$];
  logic              m_ovf;
  int                m_ovf_cnt;
  bit                model_known = 1'b0;
  int                n_tests = 0;
  int                n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // compare every DUT output against what the model says right now
  task automatic check_all();
    bit m_empty, m_full;
    m_empty = (exp_q.size() == 0);
    m_full  = (exp_q.size() == DEPTH);
    check("count",    32'(count),        32'(exp_q.size()));
    check("empty",    32'(empty),        32'(m_empty));
    check("full",     32'(full),         32'(m_full));
    check("in_ready", 32'(in_ready),     32'(!m_full));
    check("inpref_v", 32'(inpref_valid), 32'(!m_empty && !buf_output_select));
    check("wpref_v",  32'(wpref_valid),  32'(!m_empty && buf_output_select));
    check("overflow", 32'(overflow),     32'(m_ovf));
`ifdef OUT_BUF_OVF_CNT_EN
    check("ovf_cnt",  32'(ovf_count),    32'(m_ovf_cnt));
`else
    check("ovf_cnt",  32'(ovf_count),    32'd0);
`endif
    if (!m_empty) check("out_data", 32'(out_data), 32'(exp_q[0]));
  endtask

  // apply one clock edge of behaviour to the model, from the driven inputs
  task automatic model_update();
    bit wreq, ready_sel, was_full;
    logic [DATA_W-1:0] wdata;
    if (!buf_rst_n) begin
      exp_q.delete();
      m_ovf       = 1'b0;
      m_ovf_cnt   = 0;
      model_known = 1'b1;
      return;
    end
    wreq      = buf_input_select ? bn_valid : sa_valid;
    wdata     = buf_input_select ? bn_data  : sa_data;
    ready_sel = buf_output_select ? wpref_ready : inpref_ready;
    was_full  = (exp_q.size() == DEPTH);
    if (wreq && was_full) begin
      m_ovf = 1'b1;
      if (m_ovf_cnt < 255) m_ovf_cnt++;
    end
    if (flush) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() != 0 && ready_sel) void'(exp_q.pop_front());
      if (wreq && !was_full) exp_q.push_back(wdata);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    buf_rst_n = 1'b1; flush = 1'b0;
    buf_input_select = 1'b0; buf_output_select = 1'b0;
    sa_valid = 1'b0; bn_valid = 1'b0; sa_data = '0; bn_data = '0;
    inpref_ready = 1'b0; wpref_ready = 1'b0;
  endtask

  // one cycle: check outputs before the edge, advance model, take the edge
  task automatic tick();
    #2;
    if (model_known) check_all();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive_idle();
    buf_rst_n = 1'b0;
    tick();
    buf_rst_n = 1'b1;
  endtask

  task automatic write_sa(input logic [DATA_W-1:0] d);
    drive_idle(); sa_valid = 1'b1; sa_data = d; tick();
  endtask

  task automatic write_bn(input logic [DATA_W-1:0] d);
    drive_idle(); buf_input_select = 1'b1; bn_valid = 1'b1; bn_data = d; tick();
  endtask

  // drain until empty through input_pref, bounded by a cycle budget
  task automatic drain_all(input string tag);
    int budget;
    budget = 4 * DEPTH;
    drive_idle(); inpref_ready = 1'b1;
    while (empty !== 1'b1 && budget > 0) begin
      tick();
      budget--;
    end
    check({tag, "_drain_done"}, 32'(empty), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive_idle();
    do_reset();
    do_reset();

    // three SA words, no consumer ready
    write_sa(16'h0011); write_sa(16'h0022); write_sa(16'h0033);
    drive_idle();
    check("r24_count",   32'(count),        32'd3);
    check("r24_inpref",  32'(inpref_valid), 32'd1);
    check("r24_data",    32'(out_data),     32'h0011);
    check("r24_wpref",   32'(wpref_valid),  32'd0);

    // fill with BN words, then two more attempts that must drop
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++) write_bn(16'hB000 + 16'(i));
    drive_idle();
    check("r25_full",    32'(full),     32'd1);
    check("r25_inready", 32'(in_ready), 32'd0);
    check("r25_ovf",     32'(overflow), 32'd1);
`ifdef OUT_BUF_OVF_CNT_EN
    check("r25_ovfcnt",  32'(ovf_count), 32'd2);
`else
    check("r25_ovfcnt",  32'(ovf_count), 32'd0);
`endif
    check("r25_head",    32'(out_data), 32'hB000);

    // full: write attempt together with a weight_pref read
    drive_idle();
    buf_input_select = 1'b1; bn_valid = 1'b1; bn_data = 16'hDEAD;
    buf_output_select = 1'b1; wpref_ready = 1'b1;
    tick();
    drive_idle(); buf_output_select = 1'b1;
    check("r26_count",   32'(count),    32'd15);
    check("r26_head",    32'(out_data), 32'hB001);
    drain_all("r26");

    // 20 words through a toggling consumer, across the pointer wrap
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive_idle();
      sa_valid = 1'b1; sa_data = 16'($urandom);
      inpref_ready = 1'(i % 2);
      tick();
    end
    drain_all("r27");
    check("r27_count",   32'(count), 32'd0);

    // flush with a concurrent write at count=5
    do_reset();
    for (int i = 0; i < 5; i++) write_sa(16'h0500 + 16'(i));
    drive_idle(); flush = 1'b1; sa_valid = 1'b1; sa_data = 16'hF00D;
    tick();
    drive_idle();
    check("r28_count",   32'(count), 32'd0);
    check("r28_empty",   32'(empty), 32'd1);

    // reset mid-stream with count=7 and overflow set
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) write_sa(16'h7000 + 16'(i));
    for (int i = 0; i < DEPTH - 7; i++) begin
      drive_idle(); inpref_ready = 1'b1; tick();
    end
    drive_idle();
    check("r29_pre_cnt", 32'(count),    32'd7);
    check("r29_pre_ovf", 32'(overflow), 32'd1);
    buf_rst_n = 1'b0; sa_valid = 1'b1; inpref_ready = 1'b1; flush = 1'b1;
    tick();
    drive_idle();
    check("r29_count",   32'(count),        32'd0);
    check("r29_ovf",     32'(overflow),     32'd0);
    check("r29_inpref",  32'(inpref_valid), 32'd0);
    check("r29_wpref",   32'(wpref_valid),  32'd0);
    check("r29_ovfcnt",  32'(ovf_count),    32'd0);

    // randomized traffic; consumer speed alternates to visit full and empty
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      int rdy_pct;
      rdy_pct = ((i / 100) % 2 == 0) ? 20 : 80;
      drive_idle();
      buf_rst_n         = ($urandom_range(0, 299) != 0);
      flush             = ($urandom_range(0, 59) == 0);
      buf_input_select  = 1'($urandom_range(0, 1));
      buf_output_select = 1'($urandom_range(0, 1));
      sa_valid          = ($urandom_range(0, 99) < 60);
      bn_valid          = ($urandom_range(0, 99) < 60);
      sa_data           = 16'($urandom);
      bn_data           = 16'($urandom);
      inpref_ready      = ($urandom_range(0, 99) < rdy_pct);
      wpref_ready       = ($urandom_range(0, 99) < rdy_pct);
      tick();
    end
    drive_idle();
    #2;
    check_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global watchdog so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
